// File: rtl/ctrl_package_responder.sv
// ctrl_package_responder
// Far-end peer of the 2-bit control-package link. It receives a frame MSB-first,
// one dibble per clock, checks the frame length, and after a fixed turnaround
// returns either the received frame or a programmed response in the same format.
module ctrl_package_responder #(
    parameter int FRAME_BITS = 128,
    parameter int TURNAROUND = 4
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic [1:0]            in_data,
    input  logic                  in_en,
    input  logic                  echo_mode_i,
    input  logic [FRAME_BITS-1:0] resp_package_i,
    input  logic                  err_clr,
    output logic [1:0]            out_data,
    output logic                  out_dv,
    output logic [FRAME_BITS-1:0] rx_package_o,
    output logic                  rx_valid,
    output logic                  err_short,
    output logic                  err_long,
    output logic                  err_overrun,
    output logic [15:0]           frame_cnt,
    output logic [7:0]            err_cnt
);

    localparam int NDIB = FRAME_BITS / 2;
    localparam int CW   = $clog2(NDIB + 1);
    localparam logic [CW-1:0] NDIB_C   = CW'(NDIB);
    localparam logic [7:0]    GAP_INIT = 8'(TURNAROUND);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        DRAIN,
        TURN,
        SEND
    } state_t;

    state_t                state_q;
    logic [FRAME_BITS-1:0] sr_q;
    logic [FRAME_BITS-1:0] resp_q;
    logic [FRAME_BITS-1:0] rx_package_q;
    logic [CW-1:0]         dib_cnt_q;
    logic [CW-1:0]         send_cnt_q;
    logic [7:0]            gap_q;
    logic                  in_en_q;
    logic [1:0]            out_data_q;
    logic                  out_dv_q;
    logic                  rx_valid_q;
    logic                  err_short_q;
    logic                  err_long_q;
    logic                  err_overrun_q;
    logic [15:0]           frame_cnt_q;
    logic [7:0]            err_cnt_q;
    logic [7:0]            err_cnt_d;

    logic short_evt;
    logic long_evt;
    logic overrun_evt;

    // Error events are mutually exclusive: short/long only in RECV, overrun only in TURN/SEND.
    assign short_evt   = (state_q == RECV) && !in_en && (dib_cnt_q != NDIB_C);
    assign long_evt    = (state_q == RECV) &&  in_en && (dib_cnt_q == NDIB_C);
    assign overrun_evt = ((state_q == TURN) || (state_q == SEND)) && in_en && !in_en_q;

    // Error counter next state: clear beats a simultaneous event, and the count saturates.
    always_comb begin
        // NOTE: default assignment first so every path drives err_cnt_d and no latch is inferred.
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = 8'h00;
        end else if ((short_evt || long_evt || overrun_evt) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'h01;
        end
    end

    // Sticky error flags and the error counter.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            err_overrun_q <= 1'b0;
            err_cnt_q     <= 8'h00;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            err_cnt_q <= err_cnt_d;
            if (err_clr) begin
                err_short_q   <= 1'b0;
                err_long_q    <= 1'b0;
                err_overrun_q <= 1'b0;
            end else begin
                if (short_evt)   err_short_q   <= 1'b1;
                if (long_evt)    err_long_q    <= 1'b1;
                if (overrun_evt) err_overrun_q <= 1'b1;
            end
        end
    end

    // Link FSM: receive, length check, turnaround countdown and response shift-out.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            // NOTE: the wide frame registers are reset too, so the link always restarts from a known all-zero state.
            state_q      <= IDLE;
            sr_q         <= '0;
            resp_q       <= '0;
            rx_package_q <= '0;
            dib_cnt_q    <= '0;
            send_cnt_q   <= '0;
            gap_q        <= 8'h00;
            in_en_q      <= 1'b0;
            out_data_q   <= 2'b00;
            out_dv_q     <= 1'b0;
            rx_valid_q   <= 1'b0;
            frame_cnt_q  <= 16'h0000;
        end else begin
            in_en_q    <= in_en;
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_en) begin
                        sr_q      <= {{(FRAME_BITS-2){1'b0}}, in_data};
                        dib_cnt_q <= CW'(1);
                        state_q   <= RECV;
                    end
                end
                RECV: begin
                    if (in_en) begin
                        if (dib_cnt_q == NDIB_C) begin
                            // Too many dibbles: drop the frame and wait for the sender to stop.
                            state_q <= DRAIN;
                        end else begin
                            sr_q      <= {sr_q[FRAME_BITS-3:0], in_data};
                            dib_cnt_q <= dib_cnt_q + CW'(1);
                        end
                    end else if (dib_cnt_q == NDIB_C) begin
                        rx_package_q <= sr_q;
                        rx_valid_q   <= 1'b1;
                        frame_cnt_q  <= frame_cnt_q + 16'h0001;
                        resp_q       <= echo_mode_i ? sr_q : resp_package_i;
                        gap_q        <= GAP_INIT;
                        state_q      <= TURN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    if (!in_en) begin
                        state_q <= IDLE;
                    end
                end
                TURN: begin
                    // gap_q==1 on the edge that opens the burst, so out_dv rises TURNAROUND cycles after rx_valid.
                    if (gap_q == 8'h01) begin
                        out_dv_q   <= 1'b1;
                        out_data_q <= resp_q[FRAME_BITS-1 -: 2];
                        resp_q     <= {resp_q[FRAME_BITS-3:0], 2'b00};
                        send_cnt_q <= CW'(1);
                        state_q    <= SEND;
                    end else begin
                        gap_q <= gap_q - 8'h01;
                    end
                end
                SEND: begin
                    if (send_cnt_q == NDIB_C) begin
                        out_dv_q   <= 1'b0;
                        out_data_q <= 2'b00;
                        state_q    <= in_en ? DRAIN : IDLE;
                    end else begin
                        out_data_q <= resp_q[FRAME_BITS-1 -: 2];
                        resp_q     <= {resp_q[FRAME_BITS-3:0], 2'b00};
                        send_cnt_q <= send_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_data     = out_data_q;
    assign out_dv       = out_dv_q;
    assign rx_package_o = rx_package_q;
    assign rx_valid     = rx_valid_q;
    assign err_short    = err_short_q;
    assign err_long     = err_long_q;
    assign err_overrun  = err_overrun_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_ctrl_package_responder.sv
// Directed bench for ctrl_package_responder (FRAME_BITS=128, TURNAROUND=4).
// A negedge monitor reassembles response bursts and records event cycles.
module tb_ctrl_package_responder;

    localparam logic [127:0] F1 = 128'hA5B6C7D8_E9FA0B1C_2D3E4F50_61728394;
    localparam logic [127:0] F2 = 128'h5A49_3827_1605_F4E3_D2C1_B0AF_9E8D_7C6B;
    localparam logic [127:0] F4 = 128'hDEADBEEF_01020304_CAFEF00D_55AA33CC;
    localparam logic [127:0] F5 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] F6 = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
    localparam logic [127:0] F7 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    localparam logic [127:0] R1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] R2 = 128'hFEDCBA9876543210FEDCBA9876543210;

    logic         sys_clk;
    logic         rst;
    logic [1:0]   in_data;
    logic         in_en;
    logic         echo_mode_i;
    logic [127:0] resp_package_i;
    logic         err_clr;
    logic [1:0]   out_data;
    logic         out_dv;
    logic [127:0] rx_package_o;
    logic         rx_valid;
    logic         err_short;
    logic         err_long;
    logic         err_overrun;
    logic [15:0]  frame_cnt;
    logic [7:0]   err_cnt;

    int checks = 0;
    int errors = 0;

    // monitor state
    int           cyc = 0;
    int           rx_cnt = 0;
    int           rx_cyc = 0;
    int           first_cyc = 0;
    int           burst_len = 0;
    int           bursts = 0;
    int           data_leak = 0;
    logic         prev_dv = 1'b0;
    logic [127:0] out_word = '0;

    ctrl_package_responder #(.FRAME_BITS(128), .TURNAROUND(4)) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_en          (in_en),
        .echo_mode_i    (echo_mode_i),
        .resp_package_i (resp_package_i),
        .err_clr        (err_clr),
        .out_data       (out_data),
        .out_dv         (out_dv),
        .rx_package_o   (rx_package_o),
        .rx_valid       (rx_valid),
        .err_short      (err_short),
        .err_long       (err_long),
        .err_overrun    (err_overrun),
        .frame_cnt      (frame_cnt),
        .err_cnt        (err_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Sample outputs mid-cycle: count rx pulses, rebuild bursts, watch for data outside out_dv.
    always @(negedge sys_clk) begin
        if (rx_valid) begin
            rx_cnt = rx_cnt + 1;
            rx_cyc = cyc;
        end
        if (out_dv) begin
            if (!prev_dv) begin
                first_cyc = cyc;
                burst_len = 0;
                out_word  = '0;
            end
            burst_len = burst_len + 1;
            out_word  = {out_word[125:0], out_data};
        end else begin
            if (prev_dv) bursts = bursts + 1;
            if (out_data != 2'b00) data_leak = data_leak + 1;
        end
        prev_dv = out_dv;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Drive n dibbles taken cyclically from frame f, then drop in_en.
    task automatic send_frame(input logic [127:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            int idx;
            idx     = 127 - 2 * (i % 64);
            in_en   = 1'b1;
            in_data = f[idx -: 2];
            tick(1);
        end
        in_en   = 1'b0;
        in_data = 2'b00;
    endtask

    task automatic wait_bursts(input int target);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge sys_clk);
            if (bursts >= target) done = 1'b1;
        end
        if (!done) check("burst_timeout", 128'(bursts), 128'(target));
        tick(2);
    endtask

    task automatic wait_dv_high();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge sys_clk);
            if (out_dv) done = 1'b1;
        end
        if (!done) check("dv_timeout", 128'(out_dv), 128'(1));
    endtask

    initial begin
        int bursts_snap;
        rst            = 1'b1;
        in_data        = 2'b00;
        in_en          = 1'b0;
        echo_mode_i    = 1'b1;
        resp_package_i = '0;
        err_clr        = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_out_dv", 128'(out_dv), 128'(0));
        check("rst_rx_pkg", rx_package_o, '0);
        check("rst_frame_cnt", 128'(frame_cnt), 128'(0));
        check("rst_err_cnt", 128'(err_cnt), 128'(0));
        tick(1);
        rst = 1'b0;
        tick(2);

        // 1: echo of a good frame
        send_frame(F1, 64);
        wait_bursts(1);
        check("t1_rx_cnt", 128'(rx_cnt), 128'(1));
        check("t1_rx_pkg", rx_package_o, F1);
        check("t1_frame_cnt", 128'(frame_cnt), 128'(1));
        check("t1_latency", 128'(first_cyc - rx_cyc), 128'(4));
        check("t1_burst_len", 128'(burst_len), 128'(64));
        check("t1_echo", out_word, F1);

        // 2: programmed response sampled at frame end
        echo_mode_i    = 1'b0;
        resp_package_i = R1;
        send_frame(F2, 64);
        tick(2);
        resp_package_i = R2;
        wait_bursts(2);
        check("t2_resp", out_word, R1);
        check("t2_rx_pkg", rx_package_o, F2);
        check("t2_frame_cnt", 128'(frame_cnt), 128'(2));
        check("t2_latency", 128'(first_cyc - rx_cyc), 128'(4));

        // 3: short frame
        echo_mode_i = 1'b1;
        send_frame(F4, 40);
        tick(20);
        check("t3_err_short", 128'(err_short), 128'(1));
        check("t3_err_cnt", 128'(err_cnt), 128'(1));
        check("t3_rx_cnt", 128'(rx_cnt), 128'(2));
        check("t3_bursts", 128'(bursts), 128'(2));
        check("t3_rx_pkg", rx_package_o, F2);

        // 4: long frame, then a normal frame
        send_frame(F4, 70);
        tick(100);
        check("t4_err_long", 128'(err_long), 128'(1));
        check("t4_err_cnt", 128'(err_cnt), 128'(2));
        check("t4_bursts", 128'(bursts), 128'(2));
        check("t4_rx_cnt", 128'(rx_cnt), 128'(2));
        send_frame(F4, 64);
        wait_bursts(3);
        check("t4_echo", out_word, F4);
        check("t4_frame_cnt", 128'(frame_cnt), 128'(3));

        // 5: overrun during SEND
        send_frame(F5, 64);
        wait_dv_high();
        tick(10);
        send_frame(F6, 64);
        tick(3);
        check("t5_bursts", 128'(bursts), 128'(4));
        check("t5_burst_len", 128'(burst_len), 128'(64));
        check("t5_echo", out_word, F5);
        check("t5_err_overrun", 128'(err_overrun), 128'(1));
        check("t5_err_cnt", 128'(err_cnt), 128'(3));
        check("t5_rx_cnt", 128'(rx_cnt), 128'(4));
        send_frame(F7, 64);
        wait_bursts(5);
        check("t5_next_echo", out_word, F7);
        check("t5_frame_cnt", 128'(frame_cnt), 128'(5));

        // 6: reset in the middle of a burst
        send_frame(F1, 64);
        wait_dv_high();
        tick(30);
        rst = 1'b1;
        #1;
        check("t6_rst_out_dv", 128'(out_dv), 128'(0));
        check("t6_rst_out_data", 128'(out_data), 128'(0));
        check("t6_rst_frame_cnt", 128'(frame_cnt), 128'(0));
        check("t6_rst_err_cnt", 128'(err_cnt), 128'(0));
        check("t6_rst_overrun", 128'(err_overrun), 128'(0));
        tick(2);
        rst = 1'b0;
        tick(1);
        bursts_snap = bursts;
        tick(100);
        check("t6_no_resume", 128'(bursts), 128'(bursts_snap));
        check("t6_out_dv_low", 128'(out_dv), 128'(0));

        // one good frame so err_clr can be shown not to touch frame_cnt
        send_frame(F7, 64);
        wait_bursts(bursts_snap + 1);
        check("t6_frame_cnt", 128'(frame_cnt), 128'(1));

        // saturation of err_cnt
        for (int i = 0; i < 254; i++) begin
            send_frame(F5, 3);
            tick(1);
        end
        check("t6_err_cnt_fe", 128'(err_cnt), 128'(8'hFE));
        send_frame(F5, 3);
        tick(1);
        check("t6_err_cnt_ff", 128'(err_cnt), 128'(8'hFF));
        send_frame(F5, 3);
        tick(1);
        check("t6_err_cnt_sat", 128'(err_cnt), 128'(8'hFF));
        check("t6_err_short", 128'(err_short), 128'(1));

        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t6_clr_err_cnt", 128'(err_cnt), 128'(0));
        check("t6_clr_short", 128'(err_short), 128'(0));
        check("t6_clr_long", 128'(err_long), 128'(0));
        check("t6_clr_overrun", 128'(err_overrun), 128'(0));
        check("t6_clr_frame_cnt", 128'(frame_cnt), 128'(1));

        check("data_outside_dv", 128'(data_leak), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
